// File: rtl/alu_iter.sv
// alu_iter: registered, parametrised ALU with a valid/ready request port,
// predicate evaluation from a condition code and an optional iterative
// shift-add multiplier.
// Build option: define ALU_MUL_EN to include the MUL/MULH multiplier and its
// MUL state. Without it, ops 0x20/0x21 decode as reserved (MOV, flags held)
// and start_ready stays high.
// Flags are ordered {P,V,K,S,Z} (bit 4 .. bit 0). Shift/rotate ops act on B.
// WIDTH must be even and at least 4.
module alu_iter #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       operation,
  input  logic [3:0]       condition,
  input  logic [4:0]       flg_in,
  output logic [WIDTH-1:0] Q,
  output logic [4:0]       flg_out,
  output logic             result_valid
);

  localparam int F_Z = 0;
  localparam int F_S = 1;
  localparam int F_K = 2;
  localparam int F_V = 3;
  localparam int F_P = 4;

  localparam logic [5:0] OP_MOV  = 6'h00;
  localparam logic [5:0] OP_AND  = 6'h01;
  localparam logic [5:0] OP_OR   = 6'h02;
  localparam logic [5:0] OP_XOR  = 6'h03;
  localparam logic [5:0] OP_ADD  = 6'h04;
  localparam logic [5:0] OP_ADK  = 6'h05;
  localparam logic [5:0] OP_SUB  = 6'h06;
  localparam logic [5:0] OP_SBK  = 6'h07;
  localparam logic [5:0] OP_ROL  = 6'h08;
  localparam logic [5:0] OP_ROR  = 6'h09;
  localparam logic [5:0] OP_RKL  = 6'h0A;
  localparam logic [5:0] OP_RKR  = 6'h0B;
  localparam logic [5:0] OP_SHL  = 6'h0C;
  localparam logic [5:0] OP_SHR  = 6'h0D;
  localparam logic [5:0] OP_SWP  = 6'h0E;
  localparam logic [5:0] OP_ASR  = 6'h0F;
  localparam logic [5:0] OP_CMP  = 6'h10;
  localparam logic [5:0] OP_TST  = 6'h11;

  // Evaluate a condition code against a {P,V,K,S,Z} flag vector.
  function automatic logic cond_eval(input logic [3:0] cc, input logic [4:0] f);
    logic z;
    logic s;
    logic k;
    logic v;
    logic r;
    z = f[F_Z];
    s = f[F_S];
    k = f[F_K];
    v = f[F_V];
    case (cc)
      4'd0:    r = 1'b0;
      4'd1:    r = 1'b1;
      4'd2:    r = z;
      4'd3:    r = !z;
      4'd4:    r = s;
      4'd5:    r = !s;
      4'd6:    r = k;
      4'd7:    r = !k;
      4'd8:    r = v;
      4'd9:    r = !v;
      4'd10:   r = (s != v);
      4'd11:   r = (s == v);
      4'd12:   r = z || (s != v);
      4'd13:   r = !z && (s == v);
      4'd14:   r = k || z;
      4'd15:   r = !k && !z;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic             k_in_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] res_s;
  logic             upd_zs_s;
  logic [4:0]       flg_s;
  logic             accept_s;
  logic             issue_single_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_q_s;
  logic [4:0]       mul_flg_s;

  assign k_in_s = flg_in[F_K];

  // Single-cycle datapath: result and new flags from the request inputs.
  always_comb begin
    sum_s    = {(WIDTH+1){1'b0}};
    q_s      = B;
    res_s    = B;
    upd_zs_s = 1'b0;
    flg_s    = flg_in;
    case (operation)
      OP_MOV: begin
        q_s = B;
      end
      OP_AND: begin
        q_s = A & B;
        upd_zs_s = 1'b1;
      end
      OP_OR: begin
        q_s = A | B;
        upd_zs_s = 1'b1;
      end
      OP_XOR: begin
        q_s = A ^ B;
        upd_zs_s = 1'b1;
      end
      OP_ADD, OP_ADK: begin
        if (operation == OP_ADK) begin
          sum_s = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, k_in_s};
        end else begin
          sum_s = {1'b0, A} + {1'b0, B};
        end
        q_s = sum_s[WIDTH-1:0];
        flg_s[F_K] = sum_s[WIDTH];
        flg_s[F_V] = (A[WIDTH-1] == B[WIDTH-1]) && (q_s[WIDTH-1] != A[WIDTH-1]);
        upd_zs_s = 1'b1;
      end
      OP_SUB, OP_SBK, OP_CMP: begin
        // Bit WIDTH of the zero-extended difference is the borrow out.
        if (operation == OP_SBK) begin
          sum_s = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, k_in_s};
        end else begin
          sum_s = {1'b0, A} - {1'b0, B};
        end
        flg_s[F_K] = sum_s[WIDTH];
        flg_s[F_V] = (A[WIDTH-1] != B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
        res_s = sum_s[WIDTH-1:0];
        if (operation == OP_CMP) begin
          q_s = A;
        end else begin
          q_s = sum_s[WIDTH-1:0];
        end
        upd_zs_s = 1'b1;
      end
      OP_ROL: begin
        q_s = {B[WIDTH-2:0], B[WIDTH-1]};
        flg_s[F_K] = B[WIDTH-1];
        upd_zs_s = 1'b1;
      end
      OP_ROR: begin
        q_s = {B[0], B[WIDTH-1:1]};
        flg_s[F_K] = B[0];
        upd_zs_s = 1'b1;
      end
      OP_RKL: begin
        q_s = {B[WIDTH-2:0], k_in_s};
        flg_s[F_K] = B[WIDTH-1];
        upd_zs_s = 1'b1;
      end
      OP_RKR: begin
        q_s = {k_in_s, B[WIDTH-1:1]};
        flg_s[F_K] = B[0];
        upd_zs_s = 1'b1;
      end
      OP_SHL: begin
        q_s = {B[WIDTH-2:0], 1'b0};
        flg_s[F_K] = B[WIDTH-1];
        upd_zs_s = 1'b1;
      end
      OP_SHR: begin
        q_s = {1'b0, B[WIDTH-1:1]};
        flg_s[F_K] = B[0];
        upd_zs_s = 1'b1;
      end
      OP_SWP: begin
        // Rotate left by WIDTH/2; K is the last bit rotated out of the MSB.
        q_s = {B[WIDTH/2-1:0], B[WIDTH-1:WIDTH/2]};
        flg_s[F_K] = B[WIDTH/2];
        upd_zs_s = 1'b1;
      end
      OP_ASR: begin
        q_s = {B[WIDTH-1], B[WIDTH-1:1]};
        flg_s[F_K] = B[0];
        upd_zs_s = 1'b1;
      end
      OP_TST: begin
        q_s = A;
        res_s = A & B;
        upd_zs_s = 1'b1;
      end
      default: begin
        // PRD ops, reserved ops and (without the multiplier) 0x20/0x21.
        q_s = B;
      end
    endcase

    if (upd_zs_s) begin
      if (operation == OP_CMP || operation == OP_TST) begin
        flg_s[F_Z] = (res_s == {WIDTH{1'b0}});
        flg_s[F_S] = res_s[WIDTH-1];
      end else begin
        flg_s[F_Z] = (q_s == {WIDTH{1'b0}});
        flg_s[F_S] = q_s[WIDTH-1];
      end
    end else begin
      flg_s[F_Z] = flg_in[F_Z];
      flg_s[F_S] = flg_in[F_S];
    end

    if (operation[5:4] == 2'b01) begin
      flg_s[F_P] = cond_eval(condition, flg_s);
    end else begin
      flg_s[F_P] = flg_in[F_P];
    end
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [5:0] OP_MUL  = 6'h20;
  localparam logic [5:0] OP_MULH = 6'h21;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [2*WIDTH-1:0] prod_r;
  logic [2*WIDTH-1:0] prod_nxt_s;
  logic [WIDTH:0]     madd_s;
  logic [WIDTH-1:0]   mcand_r;
  logic               mulh_r;
  logic [4:0]         mflg_r;
  logic [CW-1:0]      cnt_r;
  logic               is_mul_s;

  assign start_ready    = (state_r == ST_IDLE);
  assign accept_s       = start_valid && start_ready;
  assign is_mul_s       = (operation == OP_MUL) || (operation == OP_MULH);
  assign issue_single_s = accept_s && !is_mul_s;
  assign mul_done_s     = (state_r == ST_MUL) && (cnt_r == LAST_CNT);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a multiply request occupies the block for WIDTH steps.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_mul_s) begin
          state_nxt_s = ST_MUL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand to the high half,
  // then shift the whole product (with carry) right by one.
  always_comb begin
    if (prod_r[0]) begin
      madd_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
    end else begin
      madd_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
    end
    prod_nxt_s = {madd_s, prod_r[WIDTH-1:1]};
  end

  // Multiplier operand capture and step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_r  <= {(2*WIDTH){1'b0}};
      mcand_r <= {WIDTH{1'b0}};
      mulh_r  <= 1'b0;
      mflg_r  <= 5'b00000;
      cnt_r   <= {CW{1'b0}};
    end else if (accept_s && is_mul_s) begin
      prod_r  <= {{WIDTH{1'b0}}, B};
      mcand_r <= A;
      mulh_r  <= (operation == OP_MULH);
      mflg_r  <= flg_in;
      cnt_r   <= {CW{1'b0}};
    end else if (state_r == ST_MUL) begin
      prod_r  <= prod_nxt_s;
      cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      prod_r  <= prod_r;
      cnt_r   <= cnt_r;
    end
  end

  // Multiply result and flags, taken from the product after the final step.
  always_comb begin
    mul_flg_s = mflg_r;
    if (mulh_r) begin
      mul_q_s = prod_nxt_s[2*WIDTH-1:WIDTH];
      mul_flg_s[F_K] = (prod_nxt_s[WIDTH-1:0] != {WIDTH{1'b0}});
    end else begin
      mul_q_s = prod_nxt_s[WIDTH-1:0];
      mul_flg_s[F_K] = (prod_nxt_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
    end
    mul_flg_s[F_Z] = (mul_q_s == {WIDTH{1'b0}});
    mul_flg_s[F_S] = mul_q_s[WIDTH-1];
  end
`else
  assign start_ready    = 1'b1;
  assign accept_s       = start_valid;
  assign issue_single_s = accept_s;
  assign mul_done_s     = 1'b0;
  assign mul_q_s        = {WIDTH{1'b0}};
  assign mul_flg_s      = 5'b00000;
`endif

  // Result/flag registers: load on a single-cycle accept or the final
  // multiply step; otherwise hold and drop result_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      Q            <= {WIDTH{1'b0}};
      flg_out      <= 5'b00000;
      result_valid <= 1'b0;
    end else if (issue_single_s) begin
      Q            <= q_s;
      flg_out      <= flg_s;
      result_valid <= 1'b1;
    end else if (mul_done_s) begin
      Q            <= mul_q_s;
      flg_out      <= mul_flg_s;
      result_valid <= 1'b1;
    end else begin
      Q            <= Q;
      flg_out      <= flg_out;
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter (WIDTH=12). Directed vectors push their
// expected {Q, flags}; a negedge monitor pops and compares on result_valid.
// MUL/MULH vectors are included when ALU_MUL_EN is defined.
module tb_alu_iter;
  logic        clk;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [11:0] A;
  logic [11:0] B;
  logic [5:0]  operation;
  logic [3:0]  condition;
  logic [4:0]  flg_in;
  logic [11:0] Q;
  logic [4:0]  flg_out;
  logic        result_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [11:0] exp_q[$];
  logic [4:0]  exp_f[$];
  string       exp_n[$];
  int          pulse_cyc[$];

  alu_iter #(.WIDTH(12)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .A(A), .B(B), .operation(operation), .condition(condition), .flg_in(flg_in),
    .Q(Q), .flg_out(flg_out), .result_valid(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare each result_valid pulse against the scoreboard head.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst && result_valid) begin
      pulse_cyc.push_back(cyc);
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_result got Q=%h flg=%b, no result was expected", Q, flg_out);
      end else begin
        logic [11:0] eq;
        logic [4:0]  ef;
        string       en;
        eq = exp_q.pop_front();
        ef = exp_f.pop_front();
        en = exp_n.pop_front();
        if (Q !== eq || flg_out !== ef) begin
          bad = bad + 1;
          $display("FAIL %s got Q=%h flg=%b expected Q=%h flg=%b", en, Q, flg_out, eq, ef);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  // Issue one request (called at posedge+1); optionally record its expectation.
  task automatic issue(input string name, input logic [5:0] op, input logic [11:0] a,
                       input logic [11:0] b, input logic [3:0] cc, input logic [4:0] fi,
                       input logic [11:0] eq, input logic [4:0] ef, input bit expect_it);
    int n;
    n = 0;
    while (!start_ready && n < 100) begin
      @(posedge clk); #1;
      n = n + 1;
    end
    if (!start_ready) begin
      check({name, "_ready_timeout"}, 32'(start_ready), 32'd1);
    end
    operation = op; A = a; B = b; condition = cc; flg_in = fi;
    start_valid = 1'b1;
    if (expect_it) begin
      exp_q.push_back(eq);
      exp_f.push_back(ef);
      exp_n.push_back(name);
    end
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n = n + 1;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; A = 12'h000; B = 12'h000;
    operation = 6'h00; condition = 4'h0; flg_in = 5'b00000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_Q", 32'(Q), 32'h000);
    check("reset_flg", 32'(flg_out), 32'h00);
    check("reset_valid", 32'(result_valid), 32'd0);
    check("reset_ready", 32'(start_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    //     name        op     A       B       cc     flg_in    expQ    expFlg {P,V,K,S,Z}
    issue("add_ovf", 6'h04, 12'h800, 12'h800, 4'd0, 5'b00000, 12'h000, 5'b01101, 1'b1);
    issue("sub_brw", 6'h06, 12'h000, 12'h001, 4'd0, 5'b00000, 12'hFFF, 5'b00110, 1'b1);
    issue("rkr",     6'h0B, 12'h000, 12'h001, 4'd0, 5'b00100, 12'h800, 5'b00110, 1'b1);
    issue("cmp_c14", 6'h10, 12'h005, 12'h007, 4'd14, 5'b00000, 12'h005, 5'b10110, 1'b1);
    issue("cmp_c15", 6'h10, 12'h005, 12'h007, 4'd15, 5'b00000, 12'h005, 5'b00110, 1'b1);
    issue("cmp_c10", 6'h10, 12'h005, 12'h007, 4'd10, 5'b00000, 12'h005, 5'b10110, 1'b1);
    drain();

    // Back-to-back logic ops; K and V in flg_in must be held.
    issue("b2b_and", 6'h01, 12'h0F0, 12'h0FF, 4'd0, 5'b01100, 12'h0F0, 5'b01100, 1'b1);
    issue("b2b_or",  6'h02, 12'h800, 12'h001, 4'd0, 5'b01100, 12'h801, 5'b01110, 1'b1);
    issue("b2b_xor", 6'h03, 12'h5A5, 12'h5A5, 4'd0, 5'b01100, 12'h000, 5'b01101, 1'b1);
    drain();
    if (pulse_cyc.size() >= 3) begin
      check("b2b_consecutive_1", 32'(pulse_cyc[pulse_cyc.size()-2] - pulse_cyc[pulse_cyc.size()-3]), 32'd1);
      check("b2b_consecutive_2", 32'(pulse_cyc[pulse_cyc.size()-1] - pulse_cyc[pulse_cyc.size()-2]), 32'd1);
    end else begin
      check("b2b_pulse_count", 32'(pulse_cyc.size()), 32'd3);
    end

    issue("mov_hold", 6'h00, 12'h000, 12'h123, 4'd0, 5'b11111, 12'h123, 5'b11111, 1'b1);
    issue("tst_z",    6'h11, 12'h0F0, 12'h00F, 4'd2, 5'b01100, 12'h0F0, 5'b11101, 1'b1);
    issue("prd_s",    6'h15, 12'h000, 12'h321, 4'd4, 5'b00010, 12'h321, 5'b10010, 1'b1);
    issue("prd_never",6'h1F, 12'h000, 12'h654, 4'd0, 5'b10000, 12'h654, 5'b00000, 1'b1);
    issue("adk",      6'h05, 12'h0FF, 12'h000, 4'd0, 5'b00100, 12'h100, 5'b00000, 1'b1);
    issue("sbk_ovf",  6'h07, 12'h800, 12'h000, 4'd0, 5'b00100, 12'h7FF, 5'b01000, 1'b1);
    issue("asr",      6'h0F, 12'h000, 12'h801, 4'd0, 5'b00000, 12'hC00, 5'b00110, 1'b1);
    issue("swp",      6'h0E, 12'h000, 12'h863, 4'd0, 5'b00000, 12'h8E1, 5'b00110, 1'b1);
    issue("rol",      6'h08, 12'h000, 12'h801, 4'd0, 5'b00000, 12'h003, 5'b00100, 1'b1);
    issue("ror",      6'h09, 12'h000, 12'h002, 4'd0, 5'b00100, 12'h001, 5'b00000, 1'b1);
    issue("shl",      6'h0C, 12'h000, 12'h401, 4'd0, 5'b00000, 12'h802, 5'b00010, 1'b1);
    issue("shr",      6'h0D, 12'h000, 12'h001, 4'd0, 5'b00000, 12'h000, 5'b00101, 1'b1);
    issue("rkl",      6'h0A, 12'h000, 12'h800, 4'd0, 5'b00100, 12'h001, 5'b00100, 1'b1);
    issue("reserved", 6'h3F, 12'h111, 12'h456, 4'd1, 5'b01011, 12'h456, 5'b01011, 1'b1);
    drain();

    // Outputs hold between results.
    repeat (3) @(posedge clk);
    #1;
    check("hold_Q", 32'(Q), 32'h456);
    check("hold_flg", 32'(flg_out), 32'h0B);

`ifdef ALU_MUL_EN
    issue("mul", 6'h20, 12'h040, 12'h040, 4'd0, 5'b11000, 12'h000, 5'b11101, 1'b1);
    // Request held while busy must be ignored.
    operation = 6'h00; B = 12'hABC; flg_in = 5'b00000; start_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("mul_busy_ready_%0d", i), 32'(start_ready), 32'd0);
      check($sformatf("mul_busy_valid_%0d", i), 32'(result_valid), 32'd0);
      @(posedge clk); #1;
    end
    start_valid = 1'b0;
    check("mul_done_ready", 32'(start_ready), 32'd1);
    check("mul_done_valid", 32'(result_valid), 32'd1);
    @(posedge clk); #1;
    issue("mulh", 6'h21, 12'h040, 12'h040, 4'd0, 5'b11000, 12'h001, 5'b11000, 1'b1);
    issue("mul_ff", 6'h20, 12'hFFF, 12'hFFF, 4'd0, 5'b00000, 12'h001, 5'b00100, 1'b1);
    issue("mulh_ff", 6'h21, 12'hFFF, 12'hFFF, 4'd0, 5'b00000, 12'hFFE, 5'b00110, 1'b1);
    drain();
    issue("pre_rst", 6'h00, 12'h000, 12'hABC, 4'd0, 5'b10101, 12'hABC, 5'b10101, 1'b1);
    drain();
    // Reset in the middle of a multiply; the aborted result is not expected.
    issue("mul_abort", 6'h20, 12'h123, 12'h045, 4'd0, 5'b00000, 12'h000, 5'b00000, 1'b0);
    operation = 6'h00; B = 12'h999; start_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
`else
    issue("op20_resv", 6'h20, 12'h040, 12'h777, 4'd0, 5'b00001, 12'h777, 5'b00001, 1'b1);
    check("nomul_ready", 32'(start_ready), 32'd1);
    issue("op21_resv", 6'h21, 12'h040, 12'hABC, 4'd0, 5'b10101, 12'hABC, 5'b10101, 1'b1);
    check("nomul_ready2", 32'(start_ready), 32'd1);
    drain();
`endif
    rst = 1'b1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_Q", 32'(Q), 32'h000);
    check("rst_flg", 32'(flg_out), 32'h00);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_ready", 32'(start_ready), 32'd1);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_Q", 32'(Q), 32'h000);
    check("post_rst_ready", 32'(start_ready), 32'd1);
    issue("post_rst_add", 6'h04, 12'h001, 12'h002, 4'd0, 5'b00000, 12'h003, 5'b00000, 1'b1);
    drain();
    repeat (2) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
Parametrised, registered successor to the 12-bit combinational ALU. It adds a valid/ready request port, registered result and flag outputs, real predicate evaluation from the condition code, and an optional iterative shift-add multiplier. It sits between the operand/flag registers and the writeback stage of the datapath. Multi-cycle operations stall issue through start_ready.

Parameters:
WIDTH, 12, operand/result width; must be even and at least 4.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_valid  in  1  request present
start_ready  out  1  block can accept a request; high only in IDLE
A  in  WIDTH  operand A
B  in  WIDTH  operand B
operation  in  6  opcode
condition  in  4  predicate condition code
flg_in  in  5  flags {P,V,K,S,Z} before the operation
Q  out  WIDTH  registered result
flg_out  out  5  registered flags {P,V,K,S,Z}
result_valid  out  1  one-cycle pulse; Q and flg_out are new this cycle

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, Q=0, flg_out=0, result_valid=0, start_ready=1 (start_ready is decoded from state).
- Accept: a request is accepted on a clk edge with start_valid&&start_ready. A, B, operation, condition and flg_in are captured at that edge.
- Single-cycle operations (everything except MUL/MULH):
  - Q, flg_out and result_valid=1 are registered at the accept edge, so the result appears in the next cycle.
  - Back-to-back accepts are allowed every cycle.
- Opcodes 0x00-0x0F, WIDTH-generalised: 00 MOV(Q=B), 01 AND, 02 OR, 03 XOR, 04 ADD, 05 ADK(+K), 06 SUB, 07 SBK(-K), 08 ROL, 09 ROR, 0A RKL, 0B RKR, 0C SHL, 0D SHR, 0E SWP (rotate by WIDTH/2), 0F ASR.
  - Ops 04-0F write K as the carry out, borrow out or shifted-out bit. Ops 00-03 hold K.
- Flag rules:
  - Z and S: updated from Q for ops 01-0F. Held for op 00 and for reserved ops.
  - V: updated only for ops 04-07.
    - ADD/ADK: V = A and B have the same sign and Q's sign differs from it.
    - SUB/SBK: V = A and B have different signs and Q's sign differs from A's.
    - V is held for all other ops.
  - P: held for ops below 0x10.
- Predicate ops 0x10-0x1F:
  - 10 CMP: computes A-B flags (Z, S, K=borrow, V as SUB). Q=A.
  - 11 TST: computes Z and S from A&B. K and V held. Q=A.
  - 12-1F PRD: Q=B, all flags held.
  - For every predicate op, P = cond(condition, new flags).
- Condition codes: 0 never, 1 always, 2 Z, 3 !Z, 4 S, 5 !S, 6 K, 7 !K, 8 V, 9 !V, 10 S!=V, 11 S==V, 12 Z|(S!=V), 13 !Z&(S==V), 14 K|Z, 15 !K&!Z.
- Multiply ops 0x20 MUL (low WIDTH bits) and 0x21 MULH (high WIDTH bits, unsigned):
  - FSM: IDLE -> MUL on accept, holding start_ready=0.
  - MUL state runs one shift-add step per cycle for exactly WIDTH cycles, then returns to IDLE. Q, flg_out and result_valid=1 are registered on the final step edge.
  - Accept-to-result_valid latency is WIDTH+1 cycles. start_ready is high again in the result_valid cycle.
  - Flags: Z and S from Q. K = (high half != 0) for MUL, K = (low half != 0) for MULH. V and P held.
- Reserved ops 0x22-0x3F: behave as MOV, single-cycle, all flags held.
- Boundary conditions:
  - start_valid while busy: ignored and not queued.
  - Reset mid-MUL: abort, no result_valid, all outputs return to reset values.
  - Between results, Q and flg_out hold their last values.

Optional Feature:
ALU_MUL_EN
- Defined: MUL/MULH and the MUL state are implemented as above.
- Undefined: no multiplier and no MUL state, so start_ready is permanently 1 outside reset. Ops 0x20/0x21 decode as reserved (MOV, flags held, single-cycle).

Test Plan:
- ADD A=0x800 B=0x800, flg_in=0 -> next cycle Q=0x000, Z=1, S=0, K=1, V=1, P=0, result_valid for 1 cycle.
- SUB A=0x000 B=0x001 -> Q=0xFFF, Z=0, S=1, K=1, V=0. Then RKR B=0x001 with K_in=1 -> Q=0x800, K=1.
- CMP A=0x005 B=0x007 cond=14 -> P=1, Q=0x005. Same operands with cond=15 -> P=0. cond=10 -> P=1.
- Back-to-back issue: AND, OR, XOR on consecutive cycles -> three consecutive result_valid pulses with correct Q values.
- MUL A=0x040 B=0x040 (ALU_MUL_EN) -> start_ready low for 12 cycles, result_valid on cycle 13, Q=0x000, Z=1, K=1. MULH with the same operands -> Q=0x001, K=0.
- Pulse rst at cycle 5 of a MUL, with start_valid held during busy -> no result_valid, Q=0, flg_out=0, start_ready=1 after reset; requests issued while busy are never executed.
